// File: rtl/msrv32_instr_queue_if.sv
// msrv32_instr_queue_if
// Handshake and field bundle between the fetch unit, the instruction queue
// and the decode stage.
//   master : fetch/decode side; drives flush, push request, instr, pc and
//            decode_ready, and observes every queue output.
//   slave  : the queue; drives instr_ready, decode_valid, pc, split fields,
//            count (and illegal_out when MSRV32_IQ_ILLEGAL_CHK_EN is defined).
// Optional feature macro: MSRV32_IQ_ILLEGAL_CHK_EN adds illegal_out.
interface msrv32_instr_queue_if #(
   parameter int DEPTH = 4
);
   logic                       flush_in;
   logic                       instr_valid_in;
   logic [31:0]                instr_in;
   logic [31:0]                pc_in;
   logic                       instr_ready_out;
   logic                       decode_ready_in;
   logic                       decode_valid_out;
   logic [31:0]                pc_out;
   logic [6:0]                 opcode_out;
   logic [2:0]                 funct3_out;
   logic [6:0]                 funct7_out;
   logic [4:0]                 rs1_addr_out;
   logic [4:0]                 rs2_addr_out;
   logic [4:0]                 rd_addr_out;
   logic [11:0]                csr_addr_out;
   logic [24:0]                instr_31_7_out;
   logic [$clog2(DEPTH):0]     count_out;
`ifdef MSRV32_IQ_ILLEGAL_CHK_EN
   logic                       illegal_out;
`endif

   modport master (
      output flush_in, instr_valid_in, instr_in, pc_in, decode_ready_in,
      input  instr_ready_out, decode_valid_out, pc_out, opcode_out,
             funct3_out, funct7_out, rs1_addr_out, rs2_addr_out,
             rd_addr_out, csr_addr_out, instr_31_7_out, count_out
`ifdef MSRV32_IQ_ILLEGAL_CHK_EN
      , input illegal_out
`endif
   );

   modport slave (
      input  flush_in, instr_valid_in, instr_in, pc_in, decode_ready_in,
      output instr_ready_out, decode_valid_out, pc_out, opcode_out,
             funct3_out, funct7_out, rs1_addr_out, rs2_addr_out,
             rd_addr_out, csr_addr_out, instr_31_7_out, count_out
`ifdef MSRV32_IQ_ILLEGAL_CHK_EN
      , output illegal_out
`endif
   );
endinterface

// File: rtl/msrv32_instr_queue.sv
// msrv32_instr_queue
// Instruction queue between fetch and decode. Holds up to DEPTH
// (instruction, PC) pairs and presents the head entry to decode already
// split into its RISC-V fields. With no valid head (empty or flushing) the
// fields carry NOP_INSTR and pc_out is 0, so decode always sees a legal word.
// Ports:
//   clk_in  : core clock, rising edge
//   rst_in  : synchronous active-high reset (wins over flush)
//   bus     : msrv32_instr_queue_if.slave (push/pop handshake, flush,
//             split head fields, count)
// Optional feature macro: MSRV32_IQ_ILLEGAL_CHK_EN adds bus.illegal_out,
// flagging a valid head whose opcode is not a base RV32I major opcode.
module msrv32_instr_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic                 clk_in,
   input logic                 rst_in,
   msrv32_instr_queue_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;

   logic          ready;
   logic          valid;
   logic          push;
   logic          pop;
   logic [31:0]   sel_word;

   // Handshake and next-state logic. Readiness ignores decode_ready so a full
   // queue never takes a push even when the head pops in the same cycle;
   // full/empty come from count alone since wp==rp in both cases.
   always_comb begin
      ready   = (count_q != FULL_CNT) && !bus.flush_in;
      valid   = (count_q != '0) && !bus.flush_in;
      push    = bus.instr_valid_in && ready;
      pop     = valid && bus.decode_ready_in;
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (bus.flush_in) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push) wp_d = wp_q + PW'(1);
         if (pop)  rp_d = rp_q + PW'(1);
         if (push && !pop)
            count_d = count_q + CW'(1);
         else if (pop && !push)
            count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately not reset; only pointers and count define
   // which entries are meaningful. A push coinciding with reset is dropped.
   always_ff @(posedge clk_in) begin
      if (!rst_in && push) begin
         instr_mem_q[wp_q] <= bus.instr_in;
         pc_mem_q[wp_q]    <= bus.pc_in;
      end
   end

   assign sel_word = valid ? instr_mem_q[rp_q] : NOP_INSTR;

   assign bus.instr_ready_out  = ready;
   assign bus.decode_valid_out = valid;
   assign bus.pc_out           = valid ? pc_mem_q[rp_q] : 32'h0;
   assign bus.opcode_out       = sel_word[6:0];
   assign bus.rd_addr_out      = sel_word[11:7];
   assign bus.funct3_out       = sel_word[14:12];
   assign bus.rs1_addr_out     = sel_word[19:15];
   assign bus.rs2_addr_out     = sel_word[24:20];
   assign bus.funct7_out       = sel_word[31:25];
   assign bus.csr_addr_out     = sel_word[31:20];
   assign bus.instr_31_7_out   = sel_word[31:7];
   assign bus.count_out        = count_q;

`ifdef MSRV32_IQ_ILLEGAL_CHK_EN
   logic legal_op;

   // Every base RV32I major opcode ends in 2'b11, so matching the full
   // 7-bit opcode also rejects compressed-format encodings.
   always_comb begin
      legal_op = 1'b0;
      case (sel_word[6:0])
         7'b0110111, // LUI
         7'b0010111, // AUIPC
         7'b1101111, // JAL
         7'b1100111, // JALR
         7'b1100011, // BRANCH
         7'b0000011, // LOAD
         7'b0100011, // STORE
         7'b0010011, // OP-IMM
         7'b0110011, // OP
         7'b0001111, // MISC-MEM
         7'b1110011: // SYSTEM
            legal_op = 1'b1;
         default:
            legal_op = 1'b0;
      endcase
   end

   assign bus.illegal_out = valid && !legal_op;
`endif

endmodule
